id_stage_pipelined: RTL and testbench
=====================================

Name: id_stage_pipelined

Overview:
- Parametrised instruction-decode stage for the 5-stage MIPS pipeline; successor to the fixed 32x32 decode block.
- Holds the architectural register file with WB-to-ID write-through bypass, decodes primary control, and detects load-use hazards.
- Owns the ID/EX pipeline register, with stall (bubble) and flush support.
- Sits between the IF/ID register and the EX stage.

Parameters:
- XLEN, 32, data width of registers and immediates.
- NREGS, 32, number of architectural registers (power of two, >=2).
- RAW, $clog2(NREGS), register address width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_instr  in  32  instruction word from IF/ID.
- if_pc  in  XLEN  PC+4 of that instruction.
- flush  in  1  branch/jump resolved taken in EX; kill the instruction in ID.
- wb_we  in  1  WB register write enable.
- wb_addr  in  RAW  WB destination register.
- wb_data  in  XLEN  WB write data.
- stall_if  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_pc  out  XLEN  registered PC+4.
- ex_rs_data, ex_rt_data  out  XLEN each  registered operands.
- ex_imm  out  XLEN  registered extended immediate.
- ex_rs, ex_rt, ex_rd  out  RAW each  registered register specifiers (instr fields truncated to RAW).
- ex_ctrl  out  ctrl_t  registered control bundle.

Behaviour:
- Reset (reset=0, async):
  - All NREGS registers := 0.
  - Every ID/EX output := 0; ex_valid=0.
  - stall_if is combinational from ex_* and is therefore 0 while in reset.
- Register file:
  - Write at posedge when wb_we && wb_addr!=0.
  - Register 0 always reads 0; writes to it are discarded.
- Reads are combinational. Bypass: if wb_we && wb_addr==src && src!=0, the read returns wb_data in the same cycle.
- Decode, by opcode [31:26]:
  - 0x00 R-type: reg_write, reg_dst, uses_rt.
  - 0x23 lw: mem_read, reg_write, alu_src, mem_to_reg.
  - 0x2B sw: mem_write, alu_src, uses_rt.
  - 0x04 beq and 0x05 bne: branch, uses_rt; bne also sets branch_ne.
  - 0x08 addi: reg_write, alu_src.
  - 0x0C andi and 0x0D ori: reg_write, alu_src, zext.
  - Any other opcode: all control 0 (treated as NOP) and illegal=1.
- Immediate: zext ? {0, instr[15:0]} : sign-extended instr[15:0], to XLEN.
- Load-use hazard (combinational) when all of:
  - ex_valid && ex_ctrl.mem_read && ex_rt!=0 && if_valid;
  - ex_rt==rs, or (uses_rt && ex_rt==rt).
- Next-state priority at posedge, highest first:
  1. flush: ex_valid<=0. stall_if=0, because flush overrides hazard and IF refetches.
  2. hazard: stall_if=1, ex_valid<=0 (bubble). ID/EX data fields may update; EX must ignore them.
  3. otherwise: ID/EX <= decoded values; ex_valid<=if_valid.
- Latency:
  - 1 cycle from IF/ID to ID/EX.
  - A load-use stall costs exactly 1 bubble. The next cycle the hazard clears because ex now holds the bubble.
- Simultaneous WB write and ID read of the same register: bypass value is used, no extra stall.
- Reset asserted mid-stall: outputs go to 0 immediately; stall_if=0 after reset.
- Illegal opcode propagates with ex_valid=1 and illegal=1; exception handling belongs to EX.

Decomposition:
- Package mips_pkg:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI);
  - packed struct ctrl_t {reg_write, reg_dst, alu_src, mem_read, mem_write, mem_to_reg, branch, branch_ne, zext, uses_rt, illegal}.
- Sub-module regfile_bypass (parameters XLEN, NREGS): 2 read ports, 1 write port, r0 hardwired zero, WB bypass.
- Decode, hazard and ID/EX logic stay in the top module.

Test Plan:
- Reset: hold reset=0 with random inputs -> all ex_* = 0 and stall_if=0; after release, reading r1..r31 via R-type instructions returns 0.
- Bypass: in the same cycle, wb_we=1, wb_addr=5, wb_data=0xDEADBEEF with if_instr add $3,$5,$0 -> next cycle ex_rs_data=0xDEADBEEF.
- r0 guard: wb_we=1, wb_addr=0, wb_data=0xFFFFFFFF, then read $0 -> ex_rs_data=0.
- Load-use: lw $2,0($1) followed by add $4,$2,$3 -> stall_if=1 for exactly 1 cycle and one bubble (ex_valid=0); the add then enters EX.
- Flush priority: hazard and flush asserted in the same cycle -> stall_if=0 and ex_valid=0 next cycle.
- Immediate extension:
  - addi imm 0x8000 -> ex_imm=0xFFFF8000;
  - ori imm 0x8000 -> ex_imm=0x00008000;
  - opcode 0x3F -> ex_ctrl.illegal=1, reg_write=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS decode stage: primary opcodes and the
// control bundle carried through ID/EX.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  typedef struct packed {
    logic reg_write;
    logic reg_dst;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic branch_ne;
    logic zext;
    logic uses_rt;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/id_stage_pipelined_if.sv
// IF/ID-side inputs, WB write-back and ID/EX outputs of the decode stage.
// The stage itself uses the slave modport; whoever feeds it uses master.
interface id_stage_pipelined_if
  import mips_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int RAW = $clog2(NREGS);

  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            flush;

  logic            wb_we;
  logic [RAW-1:0]  wb_addr;
  logic [XLEN-1:0] wb_data;

  logic            stall_if;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs_data;
  logic [XLEN-1:0] ex_rt_data;
  logic [XLEN-1:0] ex_imm;
  logic [RAW-1:0]  ex_rs;
  logic [RAW-1:0]  ex_rt;
  logic [RAW-1:0]  ex_rd;
  ctrl_t           ex_ctrl;

  modport master (
    output if_valid, if_instr, if_pc, flush, wb_we, wb_addr, wb_data,
    input  stall_if, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_ctrl
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, wb_we, wb_addr, wb_data,
    output stall_if, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_ctrl
  );

endinterface

// File: rtl/regfile_bypass.sv
// Architectural register file: two combinational read ports, one write port,
// r0 hardwired to zero, and same-cycle WB-to-read bypass.
module regfile_bypass #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] rs_addr,
  input  logic [$clog2(NREGS)-1:0] rt_addr,
  output logic [XLEN-1:0]          rs_data,
  output logic [XLEN-1:0]          rt_data,
  input  logic                     wb_we,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [XLEN-1:0]          wb_data
);
  localparam int RAW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && (wb_addr != RAW'(0))) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // The bypass lets the instruction in ID see a value WB is writing this cycle.
  assign rs_data = (rs_addr == RAW'(0))                ? '0      :
                   (wb_we && (wb_addr == rs_addr))     ? wb_data :
                                                         regs[rs_addr];
  assign rt_data = (rt_addr == RAW'(0))                ? '0      :
                   (wb_we && (wb_addr == rt_addr))     ? wb_data :
                                                         regs[rt_addr];

endmodule

// File: rtl/id_stage_pipelined.sv
// Instruction-decode stage of the 5-stage MIPS pipeline: register read,
// primary control decode, load-use hazard detection and the ID/EX register.
module id_stage_pipelined
  import mips_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                clk,
  input  logic                reset,
  id_stage_pipelined_if.slave bus
);
  localparam int RAW = $clog2(NREGS);

  logic [5:0]      opcode;
  logic [RAW-1:0]  rs;
  logic [RAW-1:0]  rt;
  logic [RAW-1:0]  rd;
  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            hazard;
  logic            next_valid;

  assign opcode = bus.if_instr[31:26];
  assign rs     = RAW'(bus.if_instr[25:21]);
  assign rt     = RAW'(bus.if_instr[20:16]);
  assign rd     = RAW'(bus.if_instr[15:11]);

  regfile_bypass #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .wb_we   (bus.wb_we),
    .wb_addr (bus.wb_addr),
    .wb_data (bus.wb_data)
  );

  always_comb begin
    dec_ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.reg_dst   = 1'b1;
        dec_ctrl.uses_rt   = 1'b1;
      end
      OP_LW: begin
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.uses_rt   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_ctrl.branch    = 1'b1;
        dec_ctrl.uses_rt   = 1'b1;
        dec_ctrl.branch_ne = (opcode == OP_BNE);
      end
      OP_ADDI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.zext      = 1'b1;
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase
  end

  assign imm = dec_ctrl.zext ? {{(XLEN-16){1'b0}}, bus.if_instr[15:0]}
                             : {{(XLEN-16){bus.if_instr[15]}}, bus.if_instr[15:0]};

  // rt only counts as a source for formats that actually read it; for I-type
  // ALU ops and loads it is the destination and must not cause a stall.
  assign hazard = bus.ex_valid && bus.ex_ctrl.mem_read && (bus.ex_rt != RAW'(0)) &&
                  bus.if_valid &&
                  ((bus.ex_rt == rs) || (dec_ctrl.uses_rt && (bus.ex_rt == rt)));

  // A taken branch refetches anyway, so flush suppresses the stall request.
  assign bus.stall_if = hazard && !bus.flush;
  assign next_valid   = bus.if_valid && !hazard && !bus.flush;

  // Data fields load every cycle; a bubble carries cleared control so it is inert.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ex_valid   <= 1'b0;
      bus.ex_pc      <= '0;
      bus.ex_rs_data <= '0;
      bus.ex_rt_data <= '0;
      bus.ex_imm     <= '0;
      bus.ex_rs      <= '0;
      bus.ex_rt      <= '0;
      bus.ex_rd      <= '0;
      bus.ex_ctrl    <= '0;
    end else begin
      bus.ex_valid   <= next_valid;
      bus.ex_pc      <= bus.if_pc;
      bus.ex_rs_data <= rs_data;
      bus.ex_rt_data <= rt_data;
      bus.ex_imm     <= imm;
      bus.ex_rs      <= rs;
      bus.ex_rt      <= rt;
      bus.ex_rd      <= rd;
      bus.ex_ctrl    <= next_valid ? dec_ctrl : '0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: a reference register file and
// decode table predict each ID/EX result, which is compared one cycle later.
module tb_id_stage_pipelined;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  id_stage_pipelined_if #(.XLEN(32), .NREGS(32)) bus ();

  id_stage_pipelined #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    ctrl_t       ctrl;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_regs [32];
  logic        model_ex_valid;
  logic        model_ex_memread;
  logic [4:0]  model_ex_rt;
  logic        last_stall;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [5:0]  ops [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h3F, 6'h02};

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
    n_checks++;
    if (got !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expected);
    end
  endtask

  function automatic ctrl_t model_decode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      6'h00: begin c.reg_write = 1; c.reg_dst = 1; c.uses_rt = 1; end
      6'h23: begin c.mem_read = 1; c.reg_write = 1; c.alu_src = 1; c.mem_to_reg = 1; end
      6'h2B: begin c.mem_write = 1; c.alu_src = 1; c.uses_rt = 1; end
      6'h04: begin c.branch = 1; c.uses_rt = 1; end
      6'h05: begin c.branch = 1; c.uses_rt = 1; c.branch_ne = 1; end
      6'h08: begin c.reg_write = 1; c.alu_src = 1; end
      6'h0C: begin c.reg_write = 1; c.alu_src = 1; c.zext = 1; end
      6'h0D: begin c.reg_write = 1; c.alu_src = 1; c.zext = 1; end
      default: c.illegal = 1;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return model_regs[a];
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_ex_valid   = 1'b0;
    model_ex_memread = 1'b0;
    model_ex_rt      = 5'd0;
    sb_q.delete();
  endtask

  task automatic checkScoreboard();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_empty: got no entry expected one");
    end else begin
      e = sb_q.pop_front();
      checkOutput("ex_valid", 64'(bus.ex_valid), 64'(e.valid));
      if (e.valid) begin
        checkOutput("ex_pc",      64'(bus.ex_pc),      64'(e.pc));
        checkOutput("ex_rs_data", 64'(bus.ex_rs_data), 64'(e.rs_data));
        checkOutput("ex_rt_data", 64'(bus.ex_rt_data), 64'(e.rt_data));
        checkOutput("ex_imm",     64'(bus.ex_imm),     64'(e.imm));
        checkOutput("ex_rs",      64'(bus.ex_rs),      64'(e.rs));
        checkOutput("ex_rt",      64'(bus.ex_rt),      64'(e.rt));
        checkOutput("ex_rd",      64'(bus.ex_rd),      64'(e.rd));
        checkOutput("ex_ctrl",    64'(bus.ex_ctrl),    64'(e.ctrl));
      end
    end
  endtask

  // Drives one ID cycle, predicts its outcome, then checks it after the edge.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic fl, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd);
    exp_t  e;
    ctrl_t c;
    logic [4:0] rs;
    logic [4:0] rt;
    logic  haz;
    logic  exp_stall;
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.if_pc    = pc;
    bus.flush    = fl;
    bus.wb_we    = we;
    bus.wb_addr  = wa;
    bus.wb_data  = wd;
    rs = instr[25:21];
    rt = instr[20:16];
    c  = model_decode(instr[31:26]);
    haz = model_ex_valid && model_ex_memread && (model_ex_rt != 5'd0) && v &&
          ((model_ex_rt == rs) || (c.uses_rt && (model_ex_rt == rt)));
    exp_stall = haz && !fl;
    e.valid   = v && !haz && !fl;
    e.pc      = pc;
    e.rs_data = model_read(rs, we, wa, wd);
    e.rt_data = model_read(rt, we, wa, wd);
    e.imm     = c.zext ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    e.rs      = rs;
    e.rt      = rt;
    e.rd      = instr[15:11];
    e.ctrl    = c;
    sb_q.push_back(e);
    model_ex_valid   = e.valid;
    model_ex_memread = c.mem_read;
    model_ex_rt      = rt;
    if (we && wa != 5'd0) model_regs[wa] = wd;
    @(negedge clk);
    last_stall = bus.stall_if;
    checkOutput("stall_if", 64'(bus.stall_if), 64'(exp_stall));
    @(posedge clk);
    #1;
    checkScoreboard();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_instr = 32'h0;
    bus.if_pc    = 32'h0;
    bus.flush    = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_addr  = 5'd0;
    bus.wb_data  = 32'h0;
    model_reset();

    // Reset held with random traffic: outputs stay cleared.
    for (int i = 0; i < 4; i++) begin
      bus.if_valid = 1'($urandom);
      bus.if_instr = 32'($urandom);
      bus.if_pc    = 32'($urandom);
      bus.flush    = 1'($urandom);
      bus.wb_we    = 1'b1;
      bus.wb_addr  = 5'($urandom);
      bus.wb_data  = 32'($urandom);
      @(negedge clk);
      checkOutput("rst_valid",   64'(bus.ex_valid),   64'(0));
      checkOutput("rst_stall",   64'(bus.stall_if),   64'(0));
      checkOutput("rst_pc",      64'(bus.ex_pc),      64'(0));
      checkOutput("rst_rs_data", 64'(bus.ex_rs_data), 64'(0));
      checkOutput("rst_rt_data", 64'(bus.ex_rt_data), 64'(0));
      checkOutput("rst_imm",     64'(bus.ex_imm),     64'(0));
      checkOutput("rst_regs",    64'({bus.ex_rs, bus.ex_rt, bus.ex_rd}), 64'(0));
      checkOutput("rst_ctrl",    64'(bus.ex_ctrl),    64'(0));
    end
    @(posedge clk);
    #1;
    bus.wb_we = 1'b0;
    model_reset();
    reset = 1'b1;

    for (int i = 1; i < 32; i++)
      applyStimulus(1'b1, rtype(5'(i), 5'(32 - i), 5'(i)), 32'h1000 + 32'(4 * i),
                    1'b0, 1'b0, 5'd0, 32'h0);

    for (int i = 1; i < 8; i++)
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'(i), 32'($urandom));

    applyStimulus(1'b1, rtype(5'd5, 5'd0, 5'd3), 32'h2000, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    checkOutput("bypass_rs", 64'(bus.ex_rs_data), 64'(32'hDEADBEEF));

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    applyStimulus(1'b1, rtype(5'd0, 5'd0, 5'd3), 32'h2004, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("r0_guard", 64'(bus.ex_rs_data), 64'(0));
    applyStimulus(1'b1, rtype(5'd0, 5'd0, 5'd3), 32'h2008, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    checkOutput("r0_guard_same_cycle", 64'(bus.ex_rt_data), 64'(0));

    // Load-use on rs: one stall cycle, one bubble, then the add proceeds.
    applyStimulus(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0004), 32'h3000, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b1, rtype(5'd2, 5'd3, 5'd4), 32'h3004, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("lu_stall", 64'(last_stall), 64'(1));
    checkOutput("lu_bubble", 64'(bus.ex_valid), 64'(0));
    applyStimulus(1'b1, rtype(5'd2, 5'd3, 5'd4), 32'h3004, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("lu_stall_clear", 64'(last_stall), 64'(0));
    checkOutput("lu_add_valid", 64'(bus.ex_valid), 64'(1));
    checkOutput("lu_add_pc", 64'(bus.ex_pc), 64'(32'h3004));

    applyStimulus(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0000), 32'h3100, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b1, rtype(5'd3, 5'd2, 5'd4), 32'h3104, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("lu_rt_stall", 64'(last_stall), 64'(1));
    applyStimulus(1'b1, rtype(5'd3, 5'd2, 5'd4), 32'h3104, 1'b0, 1'b0, 5'd0, 32'h0);

    applyStimulus(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0000), 32'h3200, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b1, itype(6'h08, 5'd3, 5'd2, 16'h0001), 32'h3204, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("addi_rt_no_stall", 64'(last_stall), 64'(0));

    applyStimulus(1'b1, itype(6'h23, 5'd1, 5'd0, 16'h0000), 32'h3300, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b1, rtype(5'd0, 5'd0, 5'd4), 32'h3304, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("lw_r0_no_stall", 64'(last_stall), 64'(0));

    applyStimulus(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0000), 32'h3400, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b1, rtype(5'd2, 5'd3, 5'd4), 32'h3404, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("flush_stall", 64'(last_stall), 64'(0));
    checkOutput("flush_valid", 64'(bus.ex_valid), 64'(0));

    applyStimulus(1'b1, itype(6'h08, 5'd0, 5'd1, 16'h8000), 32'h4000, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("addi_imm", 64'(bus.ex_imm), 64'(32'hFFFF8000));
    applyStimulus(1'b1, itype(6'h0D, 5'd0, 5'd1, 16'h8000), 32'h4004, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("ori_imm", 64'(bus.ex_imm), 64'(32'h00008000));
    applyStimulus(1'b1, itype(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h4008, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("illegal_valid", 64'(bus.ex_valid), 64'(1));
    checkOutput("illegal_flag", 64'(bus.ex_ctrl.illegal), 64'(1));
    checkOutput("illegal_reg_write", 64'(bus.ex_ctrl.reg_write), 64'(0));

    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 9)];
      applyStimulus(($urandom_range(0, 7) != 0),
                    {op, 2'b00, 3'($urandom), 2'b00, 3'($urandom), 16'($urandom)},
                    32'($urandom), ($urandom_range(0, 7) == 0),
                    1'($urandom), 5'($urandom_range(0, 7)), 32'($urandom));
    end

    // Reset landing in the middle of a load-use stall.
    applyStimulus(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0000), 32'h5000, 1'b0, 1'b0, 5'd0, 32'h0);
    bus.if_valid = 1'b1;
    bus.if_instr = rtype(5'd2, 5'd3, 5'd4);
    bus.if_pc    = 32'h5004;
    bus.flush    = 1'b0;
    bus.wb_we    = 1'b0;
    #2;
    checkOutput("pre_reset_stall", 64'(bus.stall_if), 64'(1));
    reset = 1'b0;
    #1;
    checkOutput("midrst_valid", 64'(bus.ex_valid), 64'(0));
    checkOutput("midrst_stall", 64'(bus.stall_if), 64'(0));
    checkOutput("midrst_pc", 64'(bus.ex_pc), 64'(0));
    checkOutput("midrst_ctrl", 64'(bus.ex_ctrl), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(1'b1, rtype(5'd1, 5'd5, 5'd6), 32'h6000, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("post_reset_r1", 64'(bus.ex_rs_data), 64'(0));
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
